// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised video timing generator. A divider turns the system clock into
// a pixel-rate tick; on each tick the horizontal counter advances and, at the
// end of a line, the vertical counter advances. Every video output is a
// register loaded from the next x/y value, so x, y, hsync, vsync and video_on
// all change on the same clk edge.
//
// Ports
//   clk          in   system clock (single domain)
//   reset        in   synchronous, active-high reset
//   enable       in   run control; low freezes divider, counters and outputs
//   pixel_tick   out  one-clk pulse on each pixel advance
//   hsync        out  horizontal sync, asserted level HSYNC_POL
//   vsync        out  vertical sync, asserted level VSYNC_POL
//   video_on     out  high while (x,y) is inside the display area
//   x, y         out  current position (CNT_W bits)
//   line_start   out  one-clk strobe when x wraps to 0
//   frame_start  out  one-clk strobe when (x,y) wraps to (0,0)
//   frame_count  out  completed frames, wraps modulo 2^16
//
// Handshake: there is no valid/ready pairing here. pixel_tick acts as a
// qualifier only: consumers may sample x/y/video_on on any clk, and the
// values stay stable for CLK_DIV clks between ticks.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 4,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // A divide-by-one still needs a 1-bit counter to keep the logic uniform.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Range bounds carry one extra bit so a display width equal to 2^CNT_W
  // still compares correctly.
  localparam logic [CNT_W:0] H_DISP_LIM = (CNT_W+1)'(H_DISPLAY);
  localparam logic [CNT_W:0] V_DISP_LIM = (CNT_W+1)'(V_DISPLAY);
  localparam logic [CNT_W:0] HS_START   = (CNT_W+1)'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W:0] HS_END     = (CNT_W+1)'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W:0] VS_START   = (CNT_W+1)'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W:0] VS_END     = (CNT_W+1)'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam logic HS_ACT = (HSYNC_POL != 0);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             tick;
  logic [CNT_W:0]   x_ext, y_ext;

  assign tick = enable && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d     = div_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    x_ext         = '0;
    y_ext         = '0;

    if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end

    if (tick) begin
      if (x_q == H_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
      end

      // Decode from the next position so the registered flags line up with
      // the registered x/y on the same edge.
      x_ext      = {1'b0, x_d};
      y_ext      = {1'b0, y_d};
      hsync_d    = ((x_ext >= HS_START) && (x_ext <= HS_END)) ? HS_ACT : ~HS_ACT;
      vsync_d    = ((y_ext >= VS_START) && (y_ext <= VS_END)) ? VS_ACT : ~VS_ACT;
      video_on_d = (x_ext < H_DISP_LIM) && (y_ext < V_DISP_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pixel_tick  = tick;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic en_c = 1'b0;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: default 640x480 timing, CLK_DIV=4, active-low syncs.
  logic a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [15:0] a_fc;
  vga_timing_gen u_a (
    .clk(clk), .reset(reset), .enable(en_a), .pixel_tick(a_tick),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  // Instance B: tiny timing, active-high syncs, CLK_DIV=1 (H_TOTAL 8, V_TOTAL 6).
  logic b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [15:0] b_fc;
  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1), .CNT_W(10)
  ) u_b (
    .clk(clk), .reset(reset), .enable(en_b), .pixel_tick(b_tick),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  // Instance C: short lines (H_TOTAL 8), default vertical timing, CLK_DIV=1.
  logic c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  logic [15:0] c_fc;
  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .CLK_DIV(1)
  ) u_c (
    .clk(clk), .reset(reset), .enable(en_c), .pixel_tick(c_tick),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .x(c_x), .y(c_y),
    .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
  );

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enabled-edge count on instance A since reset release.
  int ka = 0;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    step();
    total++; if (a_x !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", a_x); end
    total++; if (a_y !== 10'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", a_y); end
    total++; if (a_von !== 1'b1) begin bad++; $display("FAIL reset_video_on got=%0b exp=1", a_von); end
    total++; if (a_hs !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%0b exp=1", a_hs); end
    total++; if (a_vs !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%0b exp=1", a_vs); end
    total++; if (a_ls !== 1'b0) begin bad++; $display("FAIL reset_line_start got=%0b exp=0", a_ls); end
    total++; if (a_fs !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%0b exp=0", a_fs); end
    total++; if (a_fc !== 16'd0) begin bad++; $display("FAIL reset_frame_count got=%0d exp=0", a_fc); end
    total++; if (a_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b exp=0", a_tick); end
    total++; if (b_hs !== 1'b0) begin bad++; $display("FAIL reset_b_hsync got=%0b exp=0", b_hs); end
    total++; if (b_vs !== 1'b0) begin bad++; $display("FAIL reset_b_vsync got=%0b exp=0", b_vs); end
    total++; if (b_von !== 1'b1) begin bad++; $display("FAIL reset_b_video_on got=%0b exp=1", b_von); end
  endtask

  // First line of the default timing: tick every 4th clk, hsync window,
  // blanking at x=640, first line_start at clk 3200.
  task automatic test_defaults_line();
    int ex, ey;
    reset = 1'b0; en_a = 1'b1;
    for (int k = 1; k <= 3200; k++) begin
      step();
      ka = k;
      ex = (k / 4) % 800;
      ey = k / 3200;
      total++; if (a_tick !== (k % 4 == 3)) begin bad++; $display("FAIL line_tick k=%0d got=%0b", k, a_tick); end
      total++; if (a_x !== 10'(ex)) begin bad++; $display("FAIL line_x k=%0d got=%0d exp=%0d", k, a_x, ex); end
      total++; if (a_y !== 10'(ey)) begin bad++; $display("FAIL line_y k=%0d got=%0d exp=%0d", k, a_y, ey); end
      total++; if (a_hs !== !(ex >= 656 && ex <= 751)) begin bad++; $display("FAIL line_hsync k=%0d x=%0d got=%0b", k, ex, a_hs); end
      total++; if (a_von !== (ex < 640)) begin bad++; $display("FAIL line_video_on k=%0d x=%0d got=%0b", k, ex, a_von); end
      total++; if (a_ls !== (k == 3200)) begin bad++; $display("FAIL line_start k=%0d got=%0b", k, a_ls); end
      total++; if (a_vs !== 1'b1) begin bad++; $display("FAIL line_vsync k=%0d got=%0b exp=1", k, a_vs); end
    end
  endtask

  // Freeze at x=100, y=2 with the divider mid-phase, then resume.
  task automatic test_enable_freeze();
    for (int k = ka + 1; k <= 6801; k++) begin
      step();
      ka = k;
      total++; if (a_ls !== (k % 3200 == 0)) begin bad++; $display("FAIL run_line_start k=%0d got=%0b", k, a_ls); end
    end
    total++; if (a_x !== 10'd100 || a_y !== 10'd2) begin bad++; $display("FAIL freeze_pos got=%0d,%0d exp=100,2", a_x, a_y); end
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (a_x !== 10'd100) begin bad++; $display("FAIL freeze_x got=%0d exp=100", a_x); end
      total++; if (a_y !== 10'd2) begin bad++; $display("FAIL freeze_y got=%0d exp=2", a_y); end
      total++; if (a_tick !== 1'b0) begin bad++; $display("FAIL freeze_tick got=%0b exp=0", a_tick); end
      total++; if (a_hs !== 1'b1 || a_vs !== 1'b1 || a_von !== 1'b1) begin bad++; $display("FAIL freeze_flags got=%0b%0b%0b exp=111", a_hs, a_vs, a_von); end
      total++; if (a_ls !== 1'b0 || a_fs !== 1'b0) begin bad++; $display("FAIL freeze_strobes got=%0b%0b exp=00", a_ls, a_fs); end
      total++; if (a_fc !== 16'd0) begin bad++; $display("FAIL freeze_frame_count got=%0d exp=0", a_fc); end
    end
    // Held div_cnt is 1: two more edges to reach the tick phase.
    en_a = 1'b1;
    step();
    total++; if (a_tick !== 1'b0 || a_x !== 10'd100) begin bad++; $display("FAIL resume1 tick=%0b x=%0d exp=0,100", a_tick, a_x); end
    step();
    total++; if (a_tick !== 1'b1 || a_x !== 10'd100) begin bad++; $display("FAIL resume2 tick=%0b x=%0d exp=1,100", a_tick, a_x); end
    step();
    total++; if (a_tick !== 1'b0 || a_x !== 10'd101) begin bad++; $display("FAIL resume3 tick=%0b x=%0d exp=0,101", a_tick, a_x); end
    ka = 6804;
    // Run to the next line wrap, then drop enable: the strobe must clear.
    for (int k = ka + 1; k <= 9600; k++) begin
      step();
      ka = k;
    end
    total++; if (a_ls !== 1'b1 || a_x !== 10'd0 || a_y !== 10'd3) begin bad++; $display("FAIL wrap3 ls=%0b x=%0d y=%0d exp=1,0,3", a_ls, a_x, a_y); end
    en_a = 1'b0;
    step();
    total++; if (a_ls !== 1'b0 || a_x !== 10'd0 || a_y !== 10'd3) begin bad++; $display("FAIL wrap3_hold ls=%0b x=%0d y=%0d exp=0,0,3", a_ls, a_x, a_y); end
  endtask

  // Reset in the middle of the hsync pulse.
  task automatic test_reset_mid();
    en_a = 1'b1;
    for (int k = ka + 1; k <= 12400; k++) begin
      step();
      ka = k;
    end
    total++; if (a_x !== 10'd700 || a_y !== 10'd3) begin bad++; $display("FAIL mid_pos got=%0d,%0d exp=700,3", a_x, a_y); end
    total++; if (a_hs !== 1'b0 || a_von !== 1'b0) begin bad++; $display("FAIL mid_flags hs=%0b von=%0b exp=0,0", a_hs, a_von); end
    reset = 1'b1;
    step();
    total++; if (a_x !== 10'd0 || a_y !== 10'd0) begin bad++; $display("FAIL rmid_pos got=%0d,%0d exp=0,0", a_x, a_y); end
    total++; if (a_von !== 1'b1) begin bad++; $display("FAIL rmid_video_on got=%0b exp=1", a_von); end
    total++; if (a_hs !== 1'b1 || a_vs !== 1'b1) begin bad++; $display("FAIL rmid_sync got=%0b%0b exp=11", a_hs, a_vs); end
    total++; if (a_fc !== 16'd0 || a_fs !== 1'b0 || a_ls !== 1'b0) begin bad++; $display("FAIL rmid_strobes fc=%0d fs=%0b ls=%0b exp=0,0,0", a_fc, a_fs, a_ls); end
    reset = 1'b0;
    en_a = 1'b0;
    step();
    total++; if (a_x !== 10'd0 || a_tick !== 1'b0) begin bad++; $display("FAIL rmid_idle x=%0d tick=%0b exp=0,0", a_x, a_tick); end
  endtask

  // Tiny timing, active-high syncs, CLK_DIV=1: 48-clk frames.
  task automatic test_tiny_polarity();
    int ex, ey;
    en_b = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      step();
      ex = k % 8;
      ey = (k / 8) % 6;
      total++; if (b_tick !== 1'b1) begin bad++; $display("FAIL tiny_tick k=%0d got=%0b exp=1", k, b_tick); end
      total++; if (b_x !== 10'(ex) || b_y !== 10'(ey)) begin bad++; $display("FAIL tiny_pos k=%0d got=%0d,%0d exp=%0d,%0d", k, b_x, b_y, ex, ey); end
      total++; if (b_hs !== (ex >= 5 && ex <= 6)) begin bad++; $display("FAIL tiny_hsync k=%0d got=%0b", k, b_hs); end
      total++; if (b_vs !== (ey == 4)) begin bad++; $display("FAIL tiny_vsync k=%0d got=%0b", k, b_vs); end
      total++; if (b_von !== (ex < 4 && ey < 3)) begin bad++; $display("FAIL tiny_video_on k=%0d got=%0b", k, b_von); end
      total++; if (b_ls !== (k % 8 == 0)) begin bad++; $display("FAIL tiny_line_start k=%0d got=%0b", k, b_ls); end
      total++; if (b_fs !== (k % 48 == 0)) begin bad++; $display("FAIL tiny_frame_start k=%0d got=%0b", k, b_fs); end
      total++; if (b_fc !== 16'(k / 48)) begin bad++; $display("FAIL tiny_frame_count k=%0d got=%0d exp=%0d", k, b_fc, k / 48); end
    end
    en_b = 1'b0;
    step();
    total++; if (b_tick !== 1'b0 || b_x !== 10'd6) begin bad++; $display("FAIL tiny_hold tick=%0b x=%0d exp=0,6", b_tick, b_x); end
  endtask

  // Default vertical timing over one full frame plus a few lines.
  task automatic test_vsync_frame();
    int ex, ey;
    en_c = 1'b1;
    for (int k = 1; k <= 4210; k++) begin
      step();
      ex = k % 8;
      ey = (k / 8) % 525;
      total++; if (c_y !== 10'(ey)) begin bad++; $display("FAIL frame_y k=%0d got=%0d exp=%0d", k, c_y, ey); end
      total++; if (c_vs !== !(ey >= 490 && ey <= 491)) begin bad++; $display("FAIL frame_vsync k=%0d y=%0d got=%0b", k, ey, c_vs); end
      total++; if (c_von !== (ex < 4 && ey < 480)) begin bad++; $display("FAIL frame_video_on k=%0d got=%0b", k, c_von); end
      total++; if (c_fs !== (k == 4200)) begin bad++; $display("FAIL frame_start k=%0d got=%0b", k, c_fs); end
      total++; if (c_fs !== (k == 4200) || (k == 4200 && c_ls !== 1'b1)) begin bad++; $display("FAIL frame_both_strobes k=%0d fs=%0b ls=%0b", k, c_fs, c_ls); end
      total++; if (c_fc !== 16'(k / 4200)) begin bad++; $display("FAIL frame_count k=%0d got=%0d exp=%0d", k, c_fc, k / 4200); end
    end
    en_c = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_defaults_line();
    test_enable_freeze();
    test_reset_mid();
    test_tiny_polarity();
    test_vsync_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator: the successor to the fixed 640x480 sync block. It derives a pixel-rate tick from the system clock by an integer divider and runs horizontal and vertical counters over fully parametrised porch, sync and display widths. Sync polarity is programmable per axis. It drives registered, mutually aligned hsync, vsync, video_on, x and y, plus line-start and frame-start strobes and a frame counter. Pixel generators and the VGA output pins sit downstream.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync (0 = active-low)
- CLK_DIV, 4, system clocks per pixel (≥1)
- CNT_W, 10, width of x/y; H_TOTAL and V_TOTAL must be ≤ 2^CNT_W
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  run control; low freezes the divider, counters and all outputs
- pixel_tick  out  1  high for one clk on each pixel advance
- hsync  out  1  horizontal sync, asserted level HSYNC_POL
- vsync  out  1  vertical sync, asserted level VSYNC_POL
- video_on  out  1  high when (x,y) is inside the display area
- x  out  CNT_W  current horizontal position
- y  out  CNT_W  current vertical position
- line_start  out  1  one-clk strobe when x wraps to 0
- frame_start  out  1  one-clk strobe when (x,y) wraps to (0,0)
- frame_count  out  16  completed frames, wraps modulo 2^16

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK.
- Defaults: H_TOTAL 800, V_TOTAL 525.
- Divider: div_cnt counts 0..CLK_DIV-1 while enable=1.
  - pixel_tick = enable && div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick = enable.
- On pixel_tick:
  - x = (x==H_TOTAL-1) ? 0 : x+1.
  - y advances only when x==H_TOTAL-1: y = (y==V_TOTAL-1) ? 0 : y+1.
- hsync is asserted (level HSYNC_POL) for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. Otherwise it is !HSYNC_POL.
- vsync is asserted (level VSYNC_POL) for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]. Otherwise it is !VSYNC_POL.
- video_on = (x < H_DISPLAY) && (y < V_DISPLAY).
- hsync, vsync and video_on are registers computed from the next x/y values. All of x, y, hsync, vsync and video_on change on the same clk edge, with zero relative skew; no output is decoded combinationally.
- line_start is set on the edge where x loads 0 from H_TOTAL-1. It clears on the next clk edge regardless of pixel_tick.
- frame_start is set on the edge where (x,y) loads (0,0) from (H_TOTAL-1, V_TOTAL-1). On that same edge frame_count increments. frame_start clears on the next clk.
- A frame wrap asserts both line_start and frame_start.
- enable=0: div_cnt, x, y, sync outputs and frame_count hold. line_start and frame_start clear to 0. Resuming continues from the held div_cnt value.

## Timing
- Reset (sampled on the clk edge, overrides enable):
  - div_cnt=0, x=0, y=0, frame_count=0.
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - video_on=1, because (0,0) is in display.
  - line_start=0, frame_start=0.
- Reset mid-frame returns to this state on the next edge. No strobe is emitted for a reset.
- After reset release with enable=1, the first pixel_tick is at clk CLK_DIV, and x=1 is visible from the following edge.
- Line period = H_TOTAL·CLK_DIV clks. Frame period = H_TOTAL·V_TOTAL·CLK_DIV clks.
- Defaults: 3200 clks per line, 1 680 000 clks per frame.
- A consumer may sample x/y/video_on on any clk. Values are stable for CLK_DIV clks between ticks.

## Test plan
- Defaults, reset then enable=1 → pixel_tick every 4th clk. x=1 after clk 4. line_start first pulses at clk 3200 with x=0, y=1.
- Defaults → hsync=0 exactly while x=656..751. vsync=0 exactly while y=490..491. video_on=0 from x=640, y=0.
- Defaults → frame_start and line_start pulse together at clk 1 680 000. frame_count=1. Second frame_start at 3 360 000 with frame_count=2.
- HSYNC_POL=1, VSYNC_POL=1, CLK_DIV=1, tiny timing (H 4/1/2/1, V 3/1/1/1) → hsync=1 at x=5..6. vsync=1 at y=4. Frame period 48 clks. frame_count wraps 65535→0.
- enable low for 10 clks at x=100, y=20 → all outputs frozen and strobes 0. On resume, the tick phase continues from the held div_cnt.
- reset asserted at x=700, y=300 → next edge x=0, y=0, video_on=1, hsync/vsync inactive, frame_count=0, no frame_start.
